// File: rtl/riscv_pkg.sv
// Shared datapath widths, ALU opcode encoding and the ID/EX held-entry layout.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_MUL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_BNE = 3'b110,
    ALU_BEQ = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic                  use_imm;
    logic [2:0]            alu_op;
    logic                  reg_write;
    logic                  mem_read;
  } id_ex_entry_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand source select and hazard detect.
// ID_EX_FWD_EN defined: bypass from EX/MEM and MEM/WB, stall only on load-use.
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  used,
  input  logic [XLEN-1:0]       data,
  input  logic                  exMemRegWrite,
  input  logic                  exMemMemRead,
  input  logic [REG_ADDR_W-1:0] exMemRd,
  input  logic [XLEN-1:0]       exMemResult,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic [XLEN-1:0]       memWbResult,
  output logic [XLEN-1:0]       value,
  output logic                  hazard
);

  logic live;
  assign live = used && (rs != '0);

`ifdef ID_EX_FWD_EN
  always_comb begin
    value  = data;
    hazard = 1'b0;
    if (live) begin
      // A load in EX/MEM has no result yet, so it blocks rather than forwards.
      if (exMemMemRead && exMemRd == rs)        hazard = 1'b1;
      else if (exMemRegWrite && exMemRd == rs)  value  = exMemResult;
      else if (memWbRegWrite && memWbRd == rs)  value  = memWbResult;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{exMemMemRead, exMemResult, memWbResult};

  always_comb begin
    value  = data;
    hazard = live && ((exMemRegWrite && exMemRd == rs) ||
                      (memWbRegWrite && memWbRd == rs));
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute register feeding the ALU, with handshake, forwarding and RAW stall.
// Forwarding is enabled by defining ID_EX_FWD_EN; otherwise every pending write stalls.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [REG_ADDR_W-1:0] inRs1Addr,
  input  logic [REG_ADDR_W-1:0] inRs2Addr,
  input  logic [REG_ADDR_W-1:0] inRdAddr,
  input  logic [XLEN-1:0]       inRs1Data,
  input  logic [XLEN-1:0]       inRs2Data,
  input  logic [XLEN-1:0]       inImm,
  input  logic                  inUseImm,
  input  logic [2:0]            inAluOp,
  input  logic                  inRegWrite,
  input  logic                  inMemRead,
  input  logic                  flush,
  input  logic                  exMemRegWrite,
  input  logic                  exMemMemRead,
  input  logic [REG_ADDR_W-1:0] exMemRd,
  input  logic [XLEN-1:0]       exMemResult,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic [XLEN-1:0]       memWbResult,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [XLEN-1:0]       operand1,
  output logic [XLEN-1:0]       operand2,
  output logic [2:0]            aluOp,
  output logic [REG_ADDR_W-1:0] outRd,
  output logic                  outRegWrite,
  output logic                  outMemRead
);

  id_ex_entry_t          ent;
  logic                  valid;
  logic                  haz1, haz2, hazard, capture;
  logic [XLEN-1:0]       fwd1, fwd2;

  fwd_sel u_fwd1 (
    .rs(ent.rs1), .used(1'b1), .data(ent.rs1_data),
    .exMemRegWrite, .exMemMemRead, .exMemRd, .exMemResult,
    .memWbRegWrite, .memWbRd, .memWbResult,
    .value(fwd1), .hazard(haz1)
  );

  fwd_sel u_fwd2 (
    .rs(ent.rs2), .used(!ent.use_imm), .data(ent.rs2_data),
    .exMemRegWrite, .exMemMemRead, .exMemRd, .exMemResult,
    .memWbRegWrite, .memWbRd, .memWbResult,
    .value(fwd2), .hazard(haz2)
  );

  assign hazard   = valid && (haz1 || haz2);
  assign outValid = valid && !hazard;
  assign inReady  = !valid || (outReady && outValid);
  assign capture  = inValid && inReady && !flush;

  assign operand1    = fwd1;
  assign operand2    = ent.use_imm ? ent.imm : fwd2;
  assign aluOp       = ent.alu_op;
  assign outRd       = ent.rd;
  assign outRegWrite = ent.reg_write;
  assign outMemRead  = ent.mem_read;

  // Flush outranks capture and retire; fields survive a flush, only valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ent   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      ent   <= '{rs1: inRs1Addr, rs2: inRs2Addr, rd: inRdAddr,
                 rs1_data: inRs1Data, rs2_data: inRs2Data, imm: inImm,
                 use_imm: inUseImm, alu_op: inAluOp,
                 reg_write: inRegWrite, mem_read: inMemRead};
    end else if (outValid && outReady) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand-written hazard sequences.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic inValid, inReady, inUseImm, inRegWrite, inMemRead, flush;
  logic [4:0] inRs1Addr, inRs2Addr, inRdAddr, exMemRd, memWbRd, outRd;
  logic [31:0] inRs1Data, inRs2Data, inImm, exMemResult, memWbResult, operand1, operand2;
  logic [2:0] inAluOp, aluOp;
  logic exMemRegWrite, exMemMemRead, memWbRegWrite;
  logic outValid, outReady, outRegWrite, outMemRead;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr), .inRdAddr(inRdAddr),
    .inRs1Data(inRs1Data), .inRs2Data(inRs2Data), .inImm(inImm),
    .inUseImm(inUseImm), .inAluOp(inAluOp), .inRegWrite(inRegWrite),
    .inMemRead(inMemRead), .flush(flush),
    .exMemRegWrite(exMemRegWrite), .exMemMemRead(exMemMemRead),
    .exMemRd(exMemRd), .exMemResult(exMemResult),
    .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbResult(memWbResult),
    .outValid(outValid), .outReady(outReady), .operand1(operand1),
    .operand2(operand2), .aluOp(aluOp), .outRd(outRd),
    .outRegWrite(outRegWrite), .outMemRead(outMemRead)
  );

  typedef struct packed {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic [2:0]  op;
    logic        rw, mr, fl, ordy;
    logic        e_ov, e_ir;
    logic [31:0] e_op1, e_op2;
    logic [2:0]  e_aop;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr;
  } vec_t;

  function automatic vec_t mk(
    logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
    logic [31:0] d1, logic [31:0] d2, logic [31:0] imm, logic ui, logic [2:0] op,
    logic rw, logic mr, logic fl, logic ordy,
    logic e_ov, logic e_ir, logic [31:0] e_op1, logic [31:0] e_op2,
    logic [2:0] e_aop, logic [4:0] e_rd, logic e_rw, logic e_mr);
    vec_t v;
    v = '{iv, rs1, rs2, rd, d1, d2, imm, ui, op, rw, mr, fl, ordy,
          e_ov, e_ir, e_op1, e_op2, e_aop, e_rd, e_rw, e_mr};
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    inValid = 0; inRs1Addr = 0; inRs2Addr = 0; inRdAddr = 0;
    inRs1Data = 0; inRs2Data = 0; inImm = 0; inUseImm = 0; inAluOp = 0;
    inRegWrite = 0; inMemRead = 0; flush = 0; outReady = 0;
    exMemRegWrite = 0; exMemMemRead = 0; exMemRd = 0; exMemResult = 0;
    memWbRegWrite = 0; memWbRd = 0; memWbResult = 0;
  endtask

  vec_t vecs[12];

  initial begin
    //            iv rs1 rs2 rd d1     d2  imm    ui op rw mr fl rdy | ov ir op1    op2    aop rd rw mr
    vecs[0]  = mk(1, 1, 2, 3,  5,     9,  7,     1, 0, 1, 0, 0, 1,   0, 1, 0,     0,     0, 0,  0, 0);
    vecs[1]  = mk(0, 0, 0, 0,  0,     0,  0,     0, 0, 0, 0, 0, 1,   1, 1, 5,     7,     0, 3,  1, 0);
    vecs[2]  = mk(1, 2, 6, 4,  16,    32, 0,     0, 1, 1, 0, 0, 1,   0, 1, 5,     7,     0, 3,  1, 0);
    vecs[3]  = mk(1, 7, 0, 8,  'h99,  0,  0,     1, 2, 0, 0, 0, 0,   1, 0, 16,    32,    1, 4,  1, 0);
    vecs[4]  = vecs[3];
    vecs[5]  = vecs[3];
    vecs[6]  = mk(1, 3, 0, 11, 'h51,  0,  'h52,  1, 3, 0, 0, 0, 1,   1, 1, 16,    32,    1, 4,  1, 0);
    vecs[7]  = mk(0, 0, 0, 0,  0,     0,  0,     0, 0, 0, 0, 0, 0,   1, 0, 'h51,  'h52,  3, 11, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0,  0,     0,  0,     0, 0, 0, 0, 0, 1,   1, 1, 'h51,  'h52,  3, 11, 0, 0);
    vecs[9]  = mk(1, 1, 0, 9,  'h31,  0,  'h32,  1, 4, 1, 1, 0, 1,   0, 1, 'h51,  'h52,  3, 11, 0, 0);
    vecs[10] = mk(1, 2, 0, 10, 'h41,  0,  'h42,  1, 5, 1, 0, 1, 1,   1, 1, 'h31,  'h32,  4, 9,  1, 1);
    vecs[11] = mk(0, 0, 0, 0,  0,     0,  0,     0, 0, 0, 0, 0, 1,   0, 1, 'h31,  'h32,  4, 9,  1, 1);

    // Reset held for two edges while decode offers an entry.
    idle();
    rst_n = 0;
    inValid = 1; inRs1Addr = 1; inRs1Data = 32'hDEAD; inImm = 32'hBEEF; inUseImm = 1;
    inAluOp = 3'b101; inRdAddr = 7; inRegWrite = 1; outReady = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_outValid", {31'd0, outValid}, 0);
    chk("rst_operand1", operand1, 0);
    chk("rst_operand2", operand2, 0);
    chk("rst_aluOp", {29'd0, aluOp}, 0);
    idle();
    rst_n = 1;
    #1 chk("rst_inReady", {31'd0, inReady}, 1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle();
      inValid = vecs[i].iv; inRs1Addr = vecs[i].rs1; inRs2Addr = vecs[i].rs2;
      inRdAddr = vecs[i].rd; inRs1Data = vecs[i].d1; inRs2Data = vecs[i].d2;
      inImm = vecs[i].imm; inUseImm = vecs[i].ui; inAluOp = vecs[i].op;
      inRegWrite = vecs[i].rw; inMemRead = vecs[i].mr; flush = vecs[i].fl;
      outReady = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_outValid", i), {31'd0, outValid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_inReady", i), {31'd0, inReady}, {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_operand1", i), operand1, vecs[i].e_op1);
      chk($sformatf("v%0d_operand2", i), operand2, vecs[i].e_op2);
      chk($sformatf("v%0d_aluOp", i), {29'd0, aluOp}, {29'd0, vecs[i].e_aop});
      chk($sformatf("v%0d_outRd", i), {27'd0, outRd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_outRegWrite", i), {31'd0, outRegWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_outMemRead", i), {31'd0, outMemRead}, {31'd0, vecs[i].e_mr});
    end

    // Forwarding priority on rs1=3.
    @(negedge clk); idle();
    inValid = 1; inRs1Addr = 3; inRs1Data = 32'h11; inUseImm = 1; inImm = 32'h22;
    inAluOp = 3'b011; inRdAddr = 5; inRegWrite = 1;
    #1 chk("fp_capture_inReady", {31'd0, inReady}, 1);
    @(negedge clk); idle();
    exMemRegWrite = 1; exMemRd = 3; exMemResult = 32'hAA;
    memWbRegWrite = 1; memWbRd = 3; memWbResult = 32'hBB;
`ifdef ID_EX_FWD_EN
    #1;
    chk("fp_outValid", {31'd0, outValid}, 1);
    chk("fp_exmem_wins", operand1, 32'hAA);
    chk("fp_operand2_imm", operand2, 32'h22);
    exMemRegWrite = 0;
    #1 chk("fp_memwb", operand1, 32'hBB);
    memWbRegWrite = 0;
    #1 chk("fp_held", operand1, 32'h11);
`else
    #1;
    chk("fp_stall_outValid", {31'd0, outValid}, 0);
    chk("fp_stall_inReady", {31'd0, inReady}, 0);
    chk("fp_stall_operand1", operand1, 32'h11);
    @(negedge clk);
    #1 chk("fp_stall2_outValid", {31'd0, outValid}, 0);
    exMemRegWrite = 0;
    #1 chk("fp_memwb_stall", {31'd0, outValid}, 0);
    memWbRegWrite = 0;
    #1 chk("fp_release_outValid", {31'd0, outValid}, 1);
    chk("fp_release_operand1", operand1, 32'h11);
`endif
    outReady = 1;

    // x0 source is never forwarded and never stalls.
    @(negedge clk); idle();
    inValid = 1; inRs1Addr = 0; inRs1Data = 32'h66; inUseImm = 1; inImm = 1;
    @(negedge clk); idle();
    exMemRegWrite = 1; exMemRd = 0; exMemResult = 32'hAA;
    memWbRegWrite = 1; memWbRd = 0; memWbResult = 32'hBB; outReady = 1;
    #1;
    chk("x0_outValid", {31'd0, outValid}, 1);
    chk("x0_operand1", operand1, 32'h66);

    // Load-use on rs2=4, with an offered entry that must not be captured.
    @(negedge clk); idle();
    inValid = 1; inRs2Addr = 4; inRs2Data = 32'h44; inUseImm = 0;
    inAluOp = 3'b001; inRdAddr = 6; inRegWrite = 1;
    @(negedge clk); idle();
    exMemRegWrite = 1; exMemMemRead = 1; exMemRd = 4; exMemResult = 32'hEE; outReady = 1;
    inValid = 1; inRs1Addr = 9; inRs1Data = 32'h99; inAluOp = 3'b111; inRdAddr = 12;
    #1;
    chk("lu_outValid", {31'd0, outValid}, 0);
    chk("lu_inReady", {31'd0, inReady}, 0);
    @(negedge clk); idle();
    memWbRegWrite = 1; memWbRd = 4; memWbResult = 32'h55; outReady = 1;
`ifdef ID_EX_FWD_EN
    #1;
    chk("lu_release_outValid", {31'd0, outValid}, 1);
    chk("lu_operand2_fwd", operand2, 32'h55);
`else
    #1 chk("lu_memwb_stall", {31'd0, outValid}, 0);
    @(negedge clk); idle(); outReady = 1;
    #1;
    chk("lu_release_outValid", {31'd0, outValid}, 1);
    chk("lu_operand2_held", operand2, 32'h44);
`endif
    chk("lu_aluOp", {29'd0, aluOp}, 32'd1);
    chk("lu_outRd", {27'd0, outRd}, 32'd6);

    // With useImm=1, rs2 is not a dependency even against a pending load.
    @(negedge clk); idle();
    inValid = 1; inRs2Addr = 4; inRs2Data = 32'h44; inUseImm = 1; inImm = 32'h77;
    @(negedge clk); idle();
    exMemRegWrite = 1; exMemMemRead = 1; exMemRd = 4; outReady = 1;
    #1;
    chk("imm_nodep_outValid", {31'd0, outValid}, 1);
    chk("imm_nodep_operand2", operand2, 32'h77);

    @(negedge clk); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
